// File: rtl/jam_perm_sched_if.sv
// Scheduler-to-datapath bundle: run control in, cost ROM address and accumulator strobes out.
interface jam_perm_sched_if;
  logic        start;
  logic        stall;
  logic [2:0]  W;
  logic [2:0]  J;
  logic        acc_first;
  logic        acc_valid;
  logic        acc_last;
  logic [15:0] perm_cnt;
  logic        busy;
  logic        done;

  modport master (
    input  start, stall,
    output W, J, acc_first, acc_valid, acc_last, perm_cnt, busy, done
  );

  modport slave (
    output start, stall,
    input  W, J, acc_first, acc_valid, acc_last, perm_cnt, busy, done
  );
endinterface

// File: rtl/jam_perm_sched.sv
// Walks all N! worker->job permutations in lexicographic order, N FETCH cycles each plus 3 update cycles.
// stall freezes FETCH only (strobes drop the same cycle, W/J hold); start is taken only in IDLE.
module jam_perm_sched #(
  parameter int N = 8
) (
  input logic CLK,
  input logic RST,
  jam_perm_sched_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FETCH, S_PIVOT, S_SWAP, S_REVERSE, S_DONE
  } state_t;

  localparam logic [2:0] W_LAST = 3'(N - 1);

  state_t      state;
  logic [2:0]  perm [8];
  logic [2:0]  w;
  logic [2:0]  i;
  logic [15:0] perm_cnt;

  logic        piv_found;
  logic [2:0]  piv_idx;
  logic [2:0]  j;
  logic [2:0]  rev [8];
  logic        fetch_go;

  // Rightmost ascent; none found means perm is already descending.
  always_comb begin
    piv_found = 1'b0;
    piv_idx   = '0;
    for (int k = 0; k < N - 1; k++) begin
      if (perm[k] < perm[k+1]) begin
        piv_found = 1'b1;
        piv_idx   = 3'(k);
      end
    end
  end

  // Rightmost entry above the pivot that exceeds perm[i]; the suffix is descending so it always exists.
  always_comb begin
    j = '0;
    for (int k = 0; k < N; k++) begin
      if (3'(k) > i && perm[k] > perm[i])
        j = 3'(k);
    end
  end

  always_comb begin
    int src;
    src = 0;
    for (int k = 0; k < 8; k++) begin
      rev[k] = perm[k];
      src    = N + int'(i) - k;
      if (k > int'(i) && k < N)
        rev[k] = perm[src[2:0]];
    end
  end

  assign fetch_go = (state == S_FETCH) && !bus.stall;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      w        <= '0;
      i        <= '0;
      perm_cnt <= '0;
      for (int k = 0; k < 8; k++)
        perm[k] <= 3'(k);
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state    <= S_INIT;
            w        <= '0;
            perm_cnt <= '0;
            for (int k = 0; k < 8; k++)
              perm[k] <= 3'(k);
          end
        end
        S_INIT: state <= S_FETCH;
        S_FETCH: begin
          if (fetch_go) begin
            if (w == W_LAST) begin
              w        <= '0;
              perm_cnt <= perm_cnt + 16'd1;
              state    <= S_PIVOT;
            end else begin
              w <= w + 3'd1;
            end
          end
        end
        S_PIVOT: begin
          i     <= piv_idx;
          state <= piv_found ? S_SWAP : S_DONE;
        end
        S_SWAP: begin
          perm[i] <= perm[j];
          perm[j] <= perm[i];
          state   <= S_REVERSE;
        end
        S_REVERSE: begin
          for (int k = 0; k < 8; k++)
            perm[k] <= rev[k];
          state <= S_FETCH;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.W         = w;
  assign bus.J         = perm[w];
  assign bus.acc_valid = fetch_go;
  assign bus.acc_first = fetch_go && (w == 3'd0);
  assign bus.acc_last  = fetch_go && (w == W_LAST);
  assign bus.perm_cnt  = perm_cnt;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
endmodule

// File: tb/tb_jam_perm_sched.sv
// Directed bench: per-cycle vector tables for N=3 plus reset/back-to-back sequences and an N=5 scoreboard run.
module tb_jam_perm_sched;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  jam_perm_sched_if bus3();
  jam_perm_sched_if bus5();

  jam_perm_sched #(.N(3)) dut3 (.CLK(CLK), .RST(RST), .bus(bus3));
  jam_perm_sched #(.N(5)) dut5 (.CLK(CLK), .RST(RST), .bus(bus5));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit       stall;
    bit       vld;
    bit [2:0] w;
    bit [2:0] j;
    bit       first;
    bit       last;
    bit       busy;
    bit       done;
    int       cnt;
    bit       chk_wj;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] grp [6][3];

  task automatic add(input bit st, input bit vld, input bit [2:0] w, input bit [2:0] j,
                     input bit fi, input bit la, input bit bu, input bit dn,
                     input int cnt, input bit chk);
    vec_t v;
    v.stall = st; v.vld = vld; v.w = w; v.j = j; v.first = fi; v.last = la;
    v.busy = bu; v.done = dn; v.cnt = cnt; v.chk_wj = chk;
    vecs.push_back(v);
  endtask

  // One record per cycle from INIT to the IDLE cycle after DONE; alt stalls every FETCH step once
  // and holds stall high through INIT and the PIVOT/SWAP/REVERSE cycles.
  task automatic build(input bit alt);
    int cnt;
    cnt = 0;
    vecs.delete();
    add(alt, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int g = 0; g < 6; g++) begin
      for (int w = 0; w < 3; w++) begin
        if (alt) add(1, 0, 3'(w), grp[g][w], 0, 0, 1, 0, cnt, 1);
        add(0, 1, 3'(w), grp[g][w], w == 0, w == 2, 1, 0, cnt, 1);
      end
      cnt++;
      if (g < 5) begin
        repeat (3) add(alt, 0, 0, 0, 0, 0, 1, 0, cnt, 0);
      end else begin
        add(alt, 0, 0, 0, 0, 0, 1, 0, cnt, 0);
        add(alt, 0, 0, 0, 0, 0, 1, 1, cnt, 0);
      end
    end
    add(0, 0, 0, 0, 0, 0, 0, 0, cnt, 0);
  endtask

  task automatic run_table(input string tag);
    bus3.start = 1'b1;
    @(posedge CLK); #1;
    bus3.start = 1'b0;
    foreach (vecs[k]) begin
      bus3.stall = vecs[k].stall;
      #2;
      check($sformatf("%s c%0d valid", tag, k + 1), bus3.acc_valid, vecs[k].vld);
      check($sformatf("%s c%0d first", tag, k + 1), bus3.acc_first, vecs[k].first);
      check($sformatf("%s c%0d last", tag, k + 1), bus3.acc_last, vecs[k].last);
      check($sformatf("%s c%0d busy", tag, k + 1), bus3.busy, vecs[k].busy);
      check($sformatf("%s c%0d done", tag, k + 1), bus3.done, vecs[k].done);
      check($sformatf("%s c%0d perm_cnt", tag, k + 1), bus3.perm_cnt, vecs[k].cnt);
      if (vecs[k].chk_wj) begin
        check($sformatf("%s c%0d W", tag, k + 1), bus3.W, vecs[k].w);
        check($sformatf("%s c%0d J", tag, k + 1), bus3.J, vecs[k].j);
      end
      @(posedge CLK); #1;
    end
    bus3.stall = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " W"}, bus3.W, 0);
    check({tag, " J"}, bus3.J, 0);
    check({tag, " acc_first"}, bus3.acc_first, 0);
    check({tag, " acc_valid"}, bus3.acc_valid, 0);
    check({tag, " acc_last"}, bus3.acc_last, 0);
    check({tag, " perm_cnt"}, bus3.perm_cnt, 0);
    check({tag, " busy"}, bus3.busy, 0);
    check({tag, " done"}, bus3.done, 0);
  endtask

  task automatic wait_done3(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      @(posedge CLK); #3;
      if (bus3.done) seen = 1'b1;
    end
    check({tag, " done reached"}, seen, 1);
    @(posedge CLK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int       lasts, valids, widx, mask, c, done_cyc;
    bit       seen;
    bit [2:0] cur [5];
    logic [14:0] key, prev_key, first_key;

    grp = '{'{3'd0, 3'd1, 3'd2}, '{3'd0, 3'd2, 3'd1}, '{3'd1, 3'd0, 3'd2},
            '{3'd1, 3'd2, 3'd0}, '{3'd2, 3'd0, 3'd1}, '{3'd2, 3'd1, 3'd0}};
    RST = 1'b1;
    bus3.start = 1'b0; bus3.stall = 1'b0;
    bus5.start = 1'b0; bus5.stall = 1'b0;
    #2;
    check_reset_vals("reset");
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    build(1'b0);
    run_table("nostall");
    build(1'b1);
    run_table("altstall");

    // Reset in cycle 10 of a run, then a clean restart.
    bus3.start = 1'b1;
    @(posedge CLK); #1;
    bus3.start = 1'b0;
    repeat (9) @(posedge CLK);
    #2;
    check("rst c10 valid", bus3.acc_valid, 1);
    check("rst c10 W", bus3.W, 2);
    check("rst c10 J", bus3.J, 1);
    #1 RST = 1'b1;
    #1 check_reset_vals("rst async");
    @(posedge CLK); #1;
    RST = 1'b0;
    bus3.start = 1'b1;
    @(posedge CLK); #1;
    bus3.start = 1'b0;
    #2;
    check("restart init busy", bus3.busy, 1);
    check("restart init perm_cnt", bus3.perm_cnt, 0);
    for (int w = 0; w < 3; w++) begin
      @(posedge CLK); #2;
      check($sformatf("restart w%0d valid", w), bus3.acc_valid, 1);
      check($sformatf("restart w%0d J", w), bus3.J, w);
    end
    wait_done3("restart");

    // start held high: DONE cycle ignores it, the following IDLE cycle accepts it.
    bus3.start = 1'b1;
    for (int cc = 1; cc <= 40; cc++) begin
      @(posedge CLK); #3;
      check($sformatf("held c%0d done", cc), bus3.done, (cc == 36) ? 1 : 0);
      if (cc == 35) check("held c35 perm_cnt", bus3.perm_cnt, 6);
      if (cc == 37) check("held c37 busy", bus3.busy, 0);
      if (cc == 38) check("held c38 busy", bus3.busy, 1);
      if (cc == 39) begin
        check("held c39 valid", bus3.acc_valid, 1);
        check("held c39 first", bus3.acc_first, 1);
        check("held c39 J", bus3.J, 0);
        check("held c39 perm_cnt", bus3.perm_cnt, 0);
      end
    end
    bus3.start = 1'b0;
    wait_done3("held second run");

    // N=5 scoreboard: every group a permutation, strictly increasing, correct count and timing.
    lasts = 0; valids = 0; widx = 0; mask = 0; done_cyc = 0; seen = 1'b0;
    key = '0; prev_key = '0; first_key = '0;
    for (int k = 0; k < 5; k++) cur[k] = '0;
    bus5.start = 1'b1;
    @(posedge CLK); #1;
    bus5.start = 1'b0;
    c = 1;
    while (c <= 1500 && !seen) begin
      #2;
      if (bus5.acc_valid) begin
        valids++;
        check("n5 W order", bus5.W, widx);
        check("n5 first", bus5.acc_first, (widx == 0) ? 1 : 0);
        check("n5 last", bus5.acc_last, (widx == 4) ? 1 : 0);
        cur[widx % 5] = bus5.J;
        mask = mask | (1 << bus5.J);
        if (bus5.acc_last) begin
          key = {cur[0], cur[1], cur[2], cur[3], cur[4]};
          check("n5 group is permutation", mask, 31);
          if (lasts == 0) first_key = key;
          else check("n5 lex increasing", (key > prev_key) ? 1 : 0, 1);
          prev_key = key;
          lasts++;
          widx = 0;
          mask = 0;
        end else begin
          widx++;
        end
      end
      if (bus5.done) begin
        seen = 1'b1;
        done_cyc = c;
      end else begin
        @(posedge CLK); #1;
        c++;
      end
    end
    check("n5 done reached", seen, 1);
    check("n5 done cycle", done_cyc, 960);
    check("n5 acc_last count", lasts, 120);
    check("n5 acc_valid count", valids, 600);
    check("n5 perm_cnt", bus5.perm_cnt, 120);
    check("n5 first group", first_key, 15'o01234);
    check("n5 last group", prev_key, 15'o43210);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
